// File: rtl/register_file_multiport.sv
// Multi-ported register file with a hardware clear sweep, optional write-to-read
// bypass and an optional hardwired-zero register 0.
module register_file_multiport #(
    parameter int XLEN           = 32,
    parameter int NUM_REGS       = 32,
    parameter int NUM_READ_PORTS = 2,
    parameter int BYPASS         = 1,
    parameter int ZERO_REG       = 1,
    localparam int AW            = $clog2(NUM_REGS)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           write_enable,
    input  logic [AW-1:0]                  register_write_select,
    input  logic [XLEN-1:0]                register_data_write,
    input  logic [NUM_READ_PORTS*AW-1:0]   read_select,
    output logic [NUM_READ_PORTS*XLEN-1:0] register_data_read,
    input  logic                           clear_request,
    output logic                           busy,
    output logic                           write_dropped
);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    localparam logic [AW:0]   REG_COUNT  = (AW + 1)'(NUM_REGS);
    localparam logic [AW-1:0] LAST_INDEX = AW'(NUM_REGS - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   clear_index_q, clear_index_d;
    logic            write_dropped_q, write_dropped_d;
    logic [XLEN-1:0] regs_q [NUM_REGS];

    logic write_in_range;
    logic write_to_zero;
    logic write_accept;

    assign write_in_range = ({1'b0, register_write_select} < REG_COUNT);
    assign write_to_zero  = (ZERO_REG != 0) && (register_write_select == '0);
    assign write_accept   = (state_q == READY) && write_enable && write_in_range && !write_to_zero;

    assign busy          = (state_q == CLEAR);
    assign write_dropped = write_dropped_q;

    // The index-0 discard is silent; only sweep-time and out-of-range writes are flagged.
    always_comb begin
        state_d         = state_q;
        clear_index_d   = clear_index_q;
        write_dropped_d = write_enable && ((state_q == CLEAR) || !write_in_range);
        case (state_q)
            CLEAR: begin
                if (clear_index_q == LAST_INDEX) begin
                    state_d       = READY;
                    clear_index_d = '0;
                end else begin
                    clear_index_d = clear_index_q + AW'(1);
                end
            end
            READY: begin
                if (clear_request) begin
                    state_d = CLEAR;
                end
            end
            default: begin
                state_d       = CLEAR;
                clear_index_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= CLEAR;
            clear_index_q   <= '0;
            write_dropped_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            clear_index_q   <= clear_index_d;
            write_dropped_q <= write_dropped_d;
        end
    end

    // Storage has no reset of its own; the sweep zeroes one entry per edge instead.
    always_ff @(posedge clock) begin
        if (state_q == CLEAR) begin
            regs_q[clear_index_q] <= '0;
        end else if (write_accept) begin
            regs_q[register_write_select] <= register_data_write;
        end
    end

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_read
        logic [AW-1:0]   index;
        logic            valid;
        logic [XLEN-1:0] data;

        assign index = read_select[p*AW +: AW];
        assign valid = !busy && ({1'b0, index} < REG_COUNT) && !((ZERO_REG != 0) && (index == '0));

        always_comb begin
            if (!valid) begin
                data = '0;
            end else if ((BYPASS != 0) && write_accept && (index == register_write_select)) begin
                data = register_data_write;
            end else begin
                data = regs_q[index];
            end
        end

        assign register_data_read[p*XLEN +: XLEN] = data;
    end

endmodule

// File: tb/tb_register_file_multiport.sv
// Bench for register_file_multiport: a default instance and a 24-entry, 3-port,
// no-bypass, no-zero-register instance share one stimulus stream and one reference model.
module tb_register_file_multiport;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        we    = 1'b0;
    logic        clr   = 1'b0;
    logic [4:0]  wsel  = '0;
    logic [31:0] wdata = '0;
    logic [14:0] rsel  = '0;

    logic [63:0] rdA;
    logic [95:0] rdB;
    logic        busyA, busyB, dropA, dropB;

    int checks   = 0;
    int failures = 0;
    bit modelOn  = 1'b0;

    // Reference model state, index 0 = default instance, 1 = small instance
    int          nRegs   [2] = '{32, 24};
    int          nPorts  [2] = '{2, 3};
    bit          bypass  [2] = '{1'b1, 1'b0};
    bit          zeroReg [2] = '{1'b1, 1'b0};
    logic [31:0] mem     [2][32];
    int          busyLeft[2];
    logic        dropExp [2];

    register_file_multiport dutA (
        .clock                 (clock),
        .reset                 (reset),
        .write_enable          (we),
        .register_write_select (wsel),
        .register_data_write   (wdata),
        .read_select           (rsel[9:0]),
        .register_data_read    (rdA),
        .clear_request         (clr),
        .busy                  (busyA),
        .write_dropped         (dropA)
    );

    register_file_multiport #(
        .XLEN           (32),
        .NUM_REGS       (24),
        .NUM_READ_PORTS (3),
        .BYPASS         (0),
        .ZERO_REG       (0)
    ) dutB (
        .clock                 (clock),
        .reset                 (reset),
        .write_enable          (we),
        .register_write_select (wsel),
        .register_data_write   (wdata),
        .read_select           (rsel),
        .register_data_read    (rdB),
        .clear_request         (clr),
        .busy                  (busyB),
        .write_dropped         (dropB)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic w, input int sel, input logic [31:0] d, input logic c,
                                 input int r0, input int r1, input int r2);
        we    = w;
        wsel  = 5'(sel);
        wdata = d;
        clr   = c;
        rsel  = {5'(r2), 5'(r1), 5'(r0)};
    endtask

    function automatic bit wouldAccept(int c);
        return reset && (busyLeft[c] == 0) && we && (int'(wsel) < nRegs[c]) &&
               !(zeroReg[c] && (wsel == 0));
    endfunction

    function automatic logic [31:0] expRead(int c, int idx);
        if (!reset || busyLeft[c] > 0) return 32'h0;
        if (idx >= nRegs[c]) return 32'h0;
        if (zeroReg[c] && idx == 0) return 32'h0;
        if (bypass[c] && wouldAccept(c) && idx == int'(wsel)) return wdata;
        return mem[c][idx];
    endfunction

    task automatic modelReset();
        for (int c = 0; c < 2; c++) begin
            busyLeft[c] = nRegs[c];
            dropExp[c]  = 1'b0;
            for (int i = 0; i < 32; i++) mem[c][i] = 32'h0;
        end
    endtask

    // Compare every output of both instances against the model, then advance the
    // model across the coming rising edge (inputs only change just after posedge).
    always @(negedge clock) begin
        if (modelOn) begin
            if (!reset) modelReset();
            checkOutput("busyA", 64'(busyA), 64'(busyLeft[0] > 0));
            checkOutput("busyB", 64'(busyB), 64'(busyLeft[1] > 0));
            checkOutput("droppedA", 64'(dropA), 64'(dropExp[0]));
            checkOutput("droppedB", 64'(dropB), 64'(dropExp[1]));
            for (int p = 0; p < nPorts[0]; p++)
                checkOutput($sformatf("readA%0d", p), 64'(rdA[p*32 +: 32]),
                            64'(expRead(0, int'(rsel[p*5 +: 5]))));
            for (int p = 0; p < nPorts[1]; p++)
                checkOutput($sformatf("readB%0d", p), 64'(rdB[p*32 +: 32]),
                            64'(expRead(1, int'(rsel[p*5 +: 5]))));
            if (reset) begin
                for (int c = 0; c < 2; c++) begin
                    if (busyLeft[c] > 0) begin
                        dropExp[c] = we;
                        busyLeft[c]--;
                    end else begin
                        bit acc;
                        acc = wouldAccept(c);
                        dropExp[c] = we && (int'(wsel) >= nRegs[c]);
                        if (acc) mem[c][wsel] = wdata;
                        if (clr) begin
                            busyLeft[c] = nRegs[c];
                            for (int i = 0; i < 32; i++) mem[c][i] = 32'h0;
                        end
                    end
                end
            end
        end
    end

    task automatic measureSweep(input string nameA, input string nameB, input int offset);
        int edgesA = -1;
        int edgesB = -1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (!busyA && edgesA < 0) edgesA = e + offset;
            if (!busyB && edgesB < 0) edgesB = e + offset;
            if (edgesA >= 0 && edgesB >= 0) break;
        end
        checkOutput(nameA, 64'(edgesA), 64'd32);
        if (nameB != "") checkOutput(nameB, 64'(edgesB), 64'd24);
    endtask

    initial begin
        applyStimulus(1'b0, 0, 32'h0, 1'b0, 0, 0, 0);
        #1 reset = 1'b0;
        modelOn = 1'b1;
        #1;
        checkOutput("busyOnResetA", 64'(busyA), 64'd1);
        checkOutput("busyOnResetB", 64'(busyB), 64'd1);
        checkOutput("droppedOnReset", 64'(dropA), 64'd0);
        tick();
        tick();
        reset = 1'b1;
        measureSweep("sweepLenA", "sweepLenB", 0);

        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 0, 32'h0, 1'b0, i, i, i);
            #1;
            checkOutput("clearedA", 64'(rdA[31:0]), 64'd0);
            checkOutput("clearedB", 64'(rdB[95:64]), 64'd0);
            tick();
        end

        applyStimulus(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 0, 0);
        tick();
        applyStimulus(1'b0, 0, 32'h0, 1'b0, 5, 5, 5);
        #1;
        checkOutput("reg5A0", 64'(rdA[31:0]), 64'hDEADBEEF);
        checkOutput("reg5A1", 64'(rdA[63:32]), 64'hDEADBEEF);
        checkOutput("reg5B2", 64'(rdB[95:64]), 64'hDEADBEEF);
        tick();

        applyStimulus(1'b1, 0, 32'h1, 1'b0, 0, 0, 0);
        tick();
        applyStimulus(1'b0, 0, 32'h0, 1'b0, 0, 0, 0);
        #1;
        checkOutput("reg0A", 64'(rdA[31:0]), 64'd0);
        checkOutput("reg0DroppedA", 64'(dropA), 64'd0);
        checkOutput("reg0B", 64'(rdB[31:0]), 64'd1);
        tick();

        applyStimulus(1'b1, 7, 32'h12345678, 1'b0, 0, 7, 7);
        #1;
        checkOutput("bypassA1", 64'(rdA[63:32]), 64'h12345678);
        checkOutput("noBypassB1", 64'(rdB[63:32]), 64'd0);
        tick();
        applyStimulus(1'b0, 0, 32'h0, 1'b0, 0, 7, 7);
        #1;
        checkOutput("afterWriteB1", 64'(rdB[63:32]), 64'h12345678);
        tick();

        applyStimulus(1'b1, 30, 32'hCAFEF00D, 1'b0, 30, 30, 30);
        #1;
        checkOutput("idx30SameB", 64'(rdB[95:64]), 64'd0);
        tick();
        applyStimulus(1'b0, 0, 32'h0, 1'b0, 30, 30, 30);
        #1;
        checkOutput("idx30DroppedB", 64'(dropB), 64'd1);
        checkOutput("idx30DroppedA", 64'(dropA), 64'd0);
        checkOutput("idx30ReadB", 64'(rdB[95:64]), 64'd0);
        checkOutput("idx30ReadA", 64'(rdA[31:0]), 64'hCAFEF00D);
        tick();
        checkOutput("idx30PulseEndB", 64'(dropB), 64'd0);

        applyStimulus(1'b1, 3, 32'hA5, 1'b1, 3, 3, 3);
        #1;
        checkOutput("clrWriteA", 64'(rdA[31:0]), 64'hA5);
        checkOutput("clrNotBusyA", 64'(busyA), 64'd0);
        tick();
        applyStimulus(1'b1, 9, 32'h55, 1'b0, 3, 3, 3);
        #1;
        checkOutput("clrBusyA", 64'(busyA), 64'd1);
        checkOutput("clrReadA", 64'(rdA[31:0]), 64'd0);
        tick();
        applyStimulus(1'b0, 0, 32'h0, 1'b0, 3, 9, 3);
        #1;
        checkOutput("busyWriteDroppedA", 64'(dropA), 64'd1);
        checkOutput("busyWriteDroppedB", 64'(dropB), 64'd1);
        measureSweep("clrSweepLenA", "", 1);
        checkOutput("reg3ClearedA", 64'(rdA[31:0]), 64'd0);
        checkOutput("reg9NotWrittenA", 64'(rdA[63:32]), 64'd0);
        checkOutput("reg3ClearedB", 64'(rdB[31:0]), 64'd0);

        applyStimulus(1'b0, 0, 32'h0, 1'b1, 0, 0, 0);
        tick();
        clr = 1'b0;
        repeat (10) tick();
        reset = 1'b0;
        #1;
        checkOutput("midSweepResetBusy", 64'(busyA), 64'd1);
        tick();
        reset = 1'b1;
        measureSweep("restartSweepLenA", "restartSweepLenB", 0);

        for (int n = 0; n < 1500; n++) begin
            int s;
            int r [3];
            s = $urandom_range(0, 31);
            for (int p = 0; p < 3; p++)
                r[p] = ($urandom_range(0, 2) == 0) ? s : $urandom_range(0, 31);
            applyStimulus($urandom_range(0, 3) != 0, s, $urandom, $urandom_range(0, 60) == 0,
                          r[0], r[1], r[2]);
            reset = ($urandom_range(0, 300) != 0);
            tick();
        end
        reset = 1'b1;
        applyStimulus(1'b0, 0, 32'h0, 1'b0, 0, 0, 0);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file_multiport.md
REGISTER_FILE_MULTIPORT -- requirements
Module: register_file_multiport

Interface
REQ-001 Parameter XLEN, default 32, data width of every register in bits.
REQ-002 Parameter NUM_REGS, default 32, number of registers (>=2, need not be a power of two).
REQ-003 Parameter NUM_READ_PORTS, default 2, number of independent read ports (>=1).
REQ-004 Parameter BYPASS, default 1, 1 = same-cycle write data forwarded to matching read ports.
REQ-005 Parameter ZERO_REG, default 1, 1 = register 0 hardwired to zero.
REQ-006 Local AW = clog2(NUM_REGS), index width.
REQ-007 clock  input  1  single clock; all state changes on rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 write_enable  input  1  write request this cycle.
REQ-010 register_write_select  input  AW  write index.
REQ-011 register_data_write  input  XLEN  write data.
REQ-012 read_select  input  NUM_READ_PORTS*AW  packed read indices, port p at bits [p*AW +: AW].
REQ-013 register_data_read  output  NUM_READ_PORTS*XLEN  packed read data, port p at bits [p*XLEN +: XLEN].
REQ-014 clear_request  input  1  request to zero the whole file.
REQ-015 busy  output  1  high while a clear sweep is in progress.
REQ-016 write_dropped  output  1  one-cycle pulse: a write was rejected.

Function
REQ-017 FSM states CLEAR and READY; CLEAR entered on reset assertion or on clear_request sampled high in READY.
REQ-018 In CLEAR, each rising edge writes zero to register clear_index and increments clear_index; when clear_index == NUM_REGS-1 the FSM moves to READY on that edge and clear_index returns to 0.
REQ-019 A sweep therefore lasts exactly NUM_REGS clock edges; busy = (state == CLEAR), combinational from state.
REQ-020 clear_request while in CLEAR is ignored (no restart, no extension).
REQ-021 In READY, write_enable high writes register_data_write into register_write_select at the rising edge.
REQ-022 Write ignored when register_write_select >= NUM_REGS, or == 0 with ZERO_REG=1, or state is CLEAR.
REQ-023 write_dropped registered, high for one cycle after an edge where write_enable was high and the write was ignored because of CLEAR or an out-of-range index (not for the index-0 discard).
REQ-024 Write and clear_request together in READY: write takes effect on that edge; sweep starts on the next edge and later zeroes it.
REQ-025 Reads combinational: port p outputs the register at its read_select index.
REQ-026 Read returns 0 when index >= NUM_REGS, when index == 0 with ZERO_REG=1, or while busy.
REQ-027 With BYPASS=1, a port whose index equals register_write_select of a write that will be accepted this edge outputs register_data_write in the same cycle; with BYPASS=0 it outputs the stored (old) value.
REQ-028 Any number of read ports may select the same index, including the write index; all return identical data.

Reset
REQ-029 reset low asynchronously forces state=CLEAR, clear_index=0, write_dropped=0; busy therefore goes 1 immediately.
REQ-030 Register array not reset directly; cleared by the sweep starting at the first rising edge after reset goes high.
REQ-031 reset asserted mid-sweep or mid-operation restarts the sweep from index 0.
REQ-032 After reset release, busy deasserts after exactly NUM_REGS rising edges.

Verification
REQ-033 Reset release, defaults -> busy=1 for 32 edges then 0; every read of indices 0..31 returns 0x00000000.
REQ-034 READY, write 0xDEADBEEF to reg 5, then read_select port0=5, port1=5 -> both ports 0xDEADBEEF; write 0x1 to reg 0 -> reg 0 reads 0, write_dropped stays 0.
REQ-035 BYPASS=1: write 0x12345678 to reg 7 while port1 selects 7 -> port1 shows 0x12345678 same cycle; BYPASS=0 -> old value until next cycle.
REQ-036 NUM_REGS=24, NUM_READ_PORTS=3: write to index 30 -> write_dropped pulses one cycle, read of 30 returns 0; sweep lasts 24 edges.
REQ-037 clear_request in READY with simultaneous write of 0xA5 to reg 3 -> reg 3 reads 0xA5 for one cycle, then busy for 32 edges, reg 3 reads 0; write during busy -> write_dropped=1 next cycle.
REQ-038 reset asserted at sweep index 10 -> busy stays 1, full 32-edge sweep from index 0 after release.
